switch_select_driver: RTL

SWITCH_SELECT_DRIVER -- requirements
Module: switch_select_driver

---
 rtl/switch_select_driver.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/switch_select_driver.sv
`timescale 1ns/1ps
// Measures NCH asynchronous clocks over a gate window and latches the fastest one through a
// break-before-make reset/set pulse pair. Define SSD_HYST_EN to require a HYST-count margin to switch.
module switch_select_driver #(
    parameter int NCH  = 2,
    parameter int CW   = 7,
    parameter int WW   = 13,
    parameter int GATE = 200,
    parameter int DEAD = 4,
    parameter int HYST = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [NCH-1:0]         ch_clk,
    input  logic [WW-1:0]          W,
    output logic [NCH*CW-1:0]      cnt,
    output logic                   cnt_valid,
    output logic [$clog2(NCH)-1:0] sel,
    output logic [NCH-1:0]         signal,
    output logic [NCH-1:0]         signal_b,
    output logic                   latch,
    output logic                   busy
);

    localparam int SW = $clog2(NCH);
    localparam int GW = $clog2(GATE);
    localparam int DW = $clog2(DEAD + 1);
    localparam int TW = (WW > DW) ? WW : DW;
`ifdef SSD_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif
    // With the margin at zero the maximum always qualifies, so the plain decision falls out.
    localparam int HYST_M = HYST_ON ? HYST : 0;
    localparam logic [NCH-1:0] ONE = NCH'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RST  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_SET  = 2'd3;

    // Stages 0..2 synchronize, stage 3 holds the previous value for edge detection.
    logic [3:0][NCH-1:0]     sync_q, sync_d;
    logic [NCH-1:0]          edge_det;
    logic [GW-1:0]           win_q, win_d;
    logic [NCH-1:0][CW-1:0]  ccnt_q, ccnt_d, inc;
    logic [NCH-1:0][CW-1:0]  cnt_q, cnt_d;
    logic                    valid_q, valid_d;

    logic [1:0]              state_q, state_d;
    logic [TW-1:0]           tim_q, tim_d;
    logic [SW-1:0]           src_q, src_d, dst_q, dst_d, sel_q, sel_d;
    logic                    init_q, init_d;
    logic                    pend_v_q, pend_v_d, pend_ok_q, pend_ok_d;
    logic [SW-1:0]           pend_dst_q, pend_dst_d;

    logic [SW-1:0]           cand, target;
    logic [CW-1:0]           best, sel_cnt;
    logic                    hyst_ok, decide_req, go;
    logic [TW-1:0]           w_len;

    assign edge_det = sync_q[2] & ~sync_q[3];
    assign w_len    = (W == '0) ? TW'(1) : TW'(W);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sync_d = {sync_q[2:0], ch_clk};
        for (int i = 0; i < NCH; i++)
            inc[i] = (edge_det[i] && ccnt_q[i] != '1) ? ccnt_q[i] + 1'b1 : ccnt_q[i];
        win_d   = win_q;
        ccnt_d  = ccnt_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (en) begin
            if (win_q == GW'(GATE - 1)) begin
                cnt_d   = inc;
                ccnt_d  = '0;
                win_d   = '0;
                valid_d = 1'b1;
            end else begin
                ccnt_d = inc;
                win_d  = win_q + 1'b1;
            end
        end
    end

    always_comb begin
        cand = '0;
        best = cnt_q[0];
        for (int i = 1; i < NCH; i++) begin
            if (cnt_q[i] > best) begin
                best = cnt_q[i];
                cand = SW'(i);
            end
        end
        sel_cnt    = cnt_q[sel_q];
        hyst_ok    = (int'(best) >= int'(sel_cnt) + HYST_M);
        decide_req = init_q || (cand != sel_q && hyst_ok);
    end

    always_comb begin
        state_d    = state_q;
        tim_d      = tim_q;
        src_d      = src_q;
        dst_d      = dst_q;
        sel_d      = sel_q;
        init_d     = init_q;
        pend_v_d   = pend_v_q;
        pend_dst_d = pend_dst_q;
        pend_ok_d  = pend_ok_q;
        go         = 1'b0;
        target     = cand;
        case (state_q)
            S_IDLE: begin
                pend_v_d = 1'b0;
                if (valid_q) begin
                    go = decide_req;
                end else if (pend_v_q) begin
                    go     = pend_ok_q && (pend_dst_q != sel_q);
                    target = pend_dst_q;
                end
                if (go) begin
                    state_d = S_RST;
                    src_d   = sel_q;
                    dst_d   = target;
                    tim_d   = w_len - 1'b1;
                end
            end
            S_RST: begin
                if (tim_q == '0) begin
                    state_d = S_GAP;
                    tim_d   = TW'(DEAD - 1);
                end else begin
                    tim_d = tim_q - 1'b1;
                end
            end
            S_GAP: begin
                if (tim_q == '0) begin
                    state_d = S_SET;
                    tim_d   = w_len - 1'b1;
                end else begin
                    tim_d = tim_q - 1'b1;
                end
            end
            S_SET: begin
                if (tim_q == '0) begin
                    state_d = S_IDLE;
                    sel_d   = dst_q;
                    init_d  = 1'b0;
                end else begin
                    tim_d = tim_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A decision landing mid-sequence is parked; the newest one wins.
        if (valid_q && state_q != S_IDLE) begin
            pend_v_d   = 1'b1;
            pend_dst_d = cand;
            pend_ok_d  = hyst_ok;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= '0;
            win_q      <= '0;
            ccnt_q     <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            state_q    <= S_IDLE;
            tim_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            sel_q      <= '0;
            init_q     <= 1'b1;
            pend_v_q   <= 1'b0;
            pend_dst_q <= '0;
            pend_ok_q  <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            win_q      <= win_d;
            ccnt_q     <= ccnt_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            state_q    <= state_d;
            tim_q      <= tim_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            sel_q      <= sel_d;
            init_q     <= init_d;
            pend_v_q   <= pend_v_d;
            pend_dst_q <= pend_dst_d;
            pend_ok_q  <= pend_ok_d;
        end
    end

    // Pulses decode straight from state so an asynchronous reset removes them immediately.
    assign signal    = (state_q == S_SET) ? (ONE << dst_q) : '0;
    assign signal_b  = (state_q == S_RST) ? (init_q ? '1 : (ONE << src_q)) : '0;
    assign latch     = ~(|signal) & ~(|signal_b);
    assign busy      = (state_q != S_IDLE);
    assign cnt       = cnt_q;
    assign cnt_valid = valid_q;
    assign sel       = sel_q;

endmodule
